// File: rtl/uart_tx_frame_serializer.sv
// UART TX frame engine: start bit, DATA_WIDTH data bits (LSB/MSB first), optional
// parity (built only when UART_TX_PARITY_EN is defined), STOP_BITS stop bits, paced by TICK.
module uart_tx_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  MSB_FIRST,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_ODD,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  SER_DONE,
  output logic [2:0]            DBG_STATE
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  stop_q, stop_d;
  logic                  msb_q, msb_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
`endif

  // Handshake: a word is taken on any CLK edge where DATA_VALID && DATA_READY;
  // DATA_READY is high only in IDLE, so DATA_VALID while busy is simply ignored.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    msb_d   = msb_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          shift_d = P_DATA;
          msb_d   = MSB_FIRST;
          cnt_d   = '0;
          stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_ODD;
`endif
          state_d = S_ARMED;
        end
      end
      // Wait for a bit boundary so the start bit is a full period.
      S_ARMED: if (TICK) state_d = S_START;
      S_START: begin
        if (TICK) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (TICK) begin
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d  = '0;
            stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = msb_q ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                            : {1'b0, shift_q[DATA_WIDTH-1:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (TICK) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (TICK) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so TX_OUT flips on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = msb_d ? shift_d[DATA_WIDTH-1] : shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_bit_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      msb_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      msb_q   <= msb_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign TX_OUT     = tx_q;
  assign BUSY       = (state_q != S_IDLE);
  assign DATA_READY = (state_q == S_IDLE);
  assign SER_DONE   = done_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Bench for uart_tx_frame_serializer: two instances (8 data/1 stop, 12 data/2 stop)
// checked every cycle against a frame-vector model plus literal mid-bit samples.
module tb_uart_tx_frame_serializer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        TICK;
  logic        msb;
  logic        par_en;
  logic        par_odd;
  logic [15:0] pd    [2];
  logic        dv    [2];
  logic        tx    [2];
  logic        busy  [2];
  logic        ready [2];
  logic        done  [2];
  logic [2:0]  dbg0, dbg1;

  int tests = 0;
  int fails = 0;
  int dcnt0 = 0;
  bit chk_en = 1'b0;

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  always #5 CLK = ~CLK;

  uart_tx_frame_serializer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(pd[0][7:0]), .DATA_VALID(dv[0]),
    .DATA_READY(ready[0]), .MSB_FIRST(msb),
`ifdef UART_TX_PARITY_EN
    .PAR_EN(par_en), .PAR_ODD(par_odd),
`endif
    .TX_OUT(tx[0]), .BUSY(busy[0]), .SER_DONE(done[0]), .DBG_STATE(dbg0)
  );

  uart_tx_frame_serializer #(.DATA_WIDTH(12), .STOP_BITS(2)) dut1 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(pd[1][11:0]), .DATA_VALID(dv[1]),
    .DATA_READY(ready[1]), .MSB_FIRST(msb),
`ifdef UART_TX_PARITY_EN
    .PAR_EN(par_en), .PAR_ODD(par_odd),
`endif
    .TX_OUT(tx[1]), .BUSY(busy[1]), .SER_DONE(done[1]), .DBG_STATE(dbg1)
  );

  // Baud strobe: one CLK high every 16 CLK.
  initial begin
    int tcnt;
    tcnt = 0;
    TICK = 1'b0;
    forever begin
      @(negedge CLK);
      tcnt = (tcnt == 15) ? 0 : tcnt + 1;
      TICK = (tcnt == 0);
    end
  end

  // ---------------- model: whole frame as a bit vector, one entry per tick period
  typedef struct packed {
    logic [31:0] bits;
    logic [5:0]  len;
  } frame_t;

  function automatic frame_t frame_bits(input logic [15:0] d, input int dw, input logic m,
                                        input logic pe, input logic po, input int sb);
    frame_t f;
    int     n;
    logic   p;
    f.bits    = '1;   // entry 0: line idle while waiting for the first tick
    f.bits[1] = 1'b0; // start bit
    n = 2;
    p = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k < dw) begin
        f.bits[n] = m ? d[dw-1-k] : d[k];
        p = p ^ d[k];
        n++;
      end
    end
    if (pe) begin
      f.bits[n] = p ^ po;
      n++;
    end
    f.len = 6'(n + sb);
    return f;
  endfunction

  frame_t m_fr   [2];
  int     m_pos  [2] = '{0, 0};
  logic   m_busy [2] = '{1'b0, 1'b0};
  logic   m_done [2] = '{1'b0, 1'b0};

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 2; i++) begin
        m_pos[i]  <= 0;
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (dv[i]) begin
            m_fr[i]   <= frame_bits(pd[i], (i == 0) ? 8 : 12, msb, par_en & HAS_PAR,
                                    par_odd, (i == 0) ? 1 : 2);
            m_pos[i]  <= 0;
            m_busy[i] <= 1'b1;
          end
        end else if (TICK) begin
          if (m_pos[i] + 1 == int'(m_fr[i].len)) begin
            m_busy[i] <= 1'b0;
            m_pos[i]  <= 0;
            m_done[i] <= 1'b1;
          end else begin
            m_pos[i] <= m_pos[i] + 1;
          end
        end
      end
    end
  end

  // ---------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cyc_tx%0d", i), 32'(tx[i]),
              32'(m_busy[i] ? m_fr[i].bits[m_pos[i]] : 1'b1));
        check($sformatf("cyc_busy%0d", i), 32'(busy[i]), 32'(m_busy[i]));
        check($sformatf("cyc_ready%0d", i), 32'(ready[i]), 32'(!m_busy[i]));
        check($sformatf("cyc_done%0d", i), 32'(done[i]), 32'(m_done[i]));
      end
    end
  end

  always @(negedge CLK) if (done[0] === 1'b1) dcnt0 <= dcnt0 + 1;

  // ---------------- driver tasks
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      n++;
    end while (TICK !== 1'b1 && n < 100);
    if (TICK !== 1'b1) timeout_fail("wait_tick");
  endtask

  task automatic send(input int i, input logic [15:0] d);
    int n;
    @(negedge CLK);
    pd[i] = d;
    dv[i] = 1'b1;
    n = 0;
    while (m_busy[i] && n < 800) begin
      @(negedge CLK);
      n++;
    end
    if (m_busy[i]) timeout_fail("send");
    @(posedge CLK);
    @(negedge CLK);
    dv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (m_busy[i] && n < 800) begin
      @(negedge CLK);
      n++;
    end
    if (m_busy[i]) timeout_fail("wait_idle");
    @(negedge CLK);
  endtask

  // Samples TX in the middle of each of the next nb bit periods.
  task automatic sample_frame(input string name, input int i, input int nb,
                              input logic [31:0] exp);
    for (int k = 0; k < nb; k++) begin
      wait_tick();
      repeat (8) @(negedge CLK);
      check($sformatf("%s_bit%0d", name, k), 32'(tx[i]), 32'(exp[k]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    RST = 1'b0;
    msb = 1'b0;
    par_en = 1'b0;
    par_odd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pd[i] = '0;
      dv[i] = 1'b0;
    end

    // reset values
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      check("rst_tx", 32'(tx[i]), 32'd1);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_ready", 32'(ready[i]), 32'd1);
      check("rst_done", 32'(done[i]), 32'd0);
    end
    #2 RST = 1'b1;
    chk_en = 1'b1;

    // T1: LSB first 8'hA5, one SER_DONE pulse
    d0 = dcnt0;
    send(0, 16'h00A5);
    sample_frame("t1", 0, 10, 32'b1101001010);
    wait_idle(0);
    check("t1_done_pulses", 32'(dcnt0 - d0), 32'd1);

    // T2: MSB first; start bit exactly 16 CLK
    msb = 1'b1;
    send(0, 16'h00A5);
    sample_frame("t2", 0, 10, 32'b1101001010);
    wait_idle(0);
    send(0, 16'h00A5);
    wait_tick();
    n = 0;
    @(negedge CLK);
    while (tx[0] === 1'b0 && n < 40) begin
      n++;
      @(negedge CLK);
    end
    check("t2_start_width", 32'(n), 32'd16);
    wait_idle(0);
    send(0, 16'h0013);
    sample_frame("t2b", 0, 10, 32'b1110010000);
    wait_idle(0);
    msb = 1'b0;

`ifdef UART_TX_PARITY_EN
    // T3: even then odd parity on 8'h07
    par_en = 1'b1;
    par_odd = 1'b0;
    send(0, 16'h0007);
    sample_frame("t3e", 0, 11, 32'b11000001110);
    wait_idle(0);
    par_odd = 1'b1;
    send(0, 16'h0007);
    sample_frame("t3o", 0, 11, 32'b10000001110);
    wait_idle(0);
    par_en = 1'b0;
    par_odd = 1'b0;
`endif

    // T4: DATA_VALID held; second word taken in the SER_DONE cycle
    @(negedge CLK);
    pd[0] = 16'h0055;
    dv[0] = 1'b1;
    n = 0;
    while (m_busy[0] && n < 800) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    @(negedge CLK);
    pd[0] = 16'h00FF;
    sample_frame("t4a", 0, 10, 32'b1010101010);
    n = 0;
    while (done[0] !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("t4_done", 32'(done[0]), 32'd1);
    check("t4_ready_in_done", 32'(ready[0]), 32'd1);
    n = 0;
    while (tx[0] !== 1'b0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("t4_gap_clk", 32'(n), 32'd16);
    check("t4_busy", 32'(busy[0]), 32'd1);
    dv[0] = 1'b0;
    pd[0] = 16'h0000;
    sample_frame("t4b", 0, 9, 32'h1FF);
    wait_idle(0);

    // T5: 12 data bits, 2 stop bits
    send(1, 16'h0F0F);
    sample_frame("t5", 1, 15, 32'b111111000011110);
    wait_idle(1);
    send(1, 16'h05A3);
    wait_tick();
    n = 0;
    do begin
      @(negedge CLK);
      if (busy[1] === 1'b1) n++;
    end while (busy[1] === 1'b1 && n < 400);
    check("t5_busy_clk", 32'(n), 32'd240);
    check("t5_done", 32'(done[1]), 32'd1);
    wait_idle(1);

    // T6: reset during data bit 4, then a clean frame
    send(0, 16'h00A5);
    repeat (6) wait_tick();
    repeat (5) @(negedge CLK);
    #3 RST = 1'b0;
    #1;
    check("t6_tx", 32'(tx[0]), 32'd1);
    check("t6_busy", 32'(busy[0]), 32'd0);
    check("t6_ready", 32'(ready[0]), 32'd1);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    send(0, 16'h003C);
    sample_frame("t6", 0, 10, 32'b1001111000);
    wait_idle(0);

    repeat (4) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
